ysyx_22041071_div_issue_ctrl: RTL and testbench

//  Sequences the shared iterative divider for EXE-stage RV64M DIV/REM ops (incl. W forms).

---
 rtl/ysyx_22041071_div_issue_ctrl_if.sv | 39 +++
 rtl/ysyx_22041071_div_issue_ctrl.sv | 118 +++++++++++
 tb/tb_ysyx_22041071_div_issue_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041071_div_issue_ctrl_if.sv
// Handshake bundle between EXE, writeback, the divider and the
// divide issue controller. The controller uses the slave view.
interface ysyx_22041071_div_issue_ctrl_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            ex_valid;
    logic [3:0]      ex_op;
    logic [XLEN-1:0] ex_src1;
    logic [XLEN-1:0] ex_src2;
    logic            ex_stall;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic            div_valid;
    logic            div_signed;
    logic            div_w;
    logic            div_flush;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic            div_ready;
    logic            div_out_valid;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_rema;

    modport slave (
        input  flush, ex_valid, ex_op, ex_src1, ex_src2, res_ready,
               div_ready, div_out_valid, div_quot, div_rema,
        output ex_stall, res_valid, res_data, div_valid, div_signed, div_w,
               div_flush, div_dividend, div_divisor
    );

    modport master (
        output flush, ex_valid, ex_op, ex_src1, ex_src2, res_ready,
               div_ready, div_out_valid, div_quot, div_rema,
        input  ex_stall, res_valid, res_data, div_valid, div_signed, div_w,
               div_flush, div_dividend, div_divisor
    );
endinterface

// File: rtl/ysyx_22041071_div_issue_ctrl.sv
// Issue controller for the shared iterative divider (RV64M DIV/REM incl. W).
// Divide-by-zero and signed overflow are resolved here without the divider;
// everything else is handed to the divider and its one-cycle result held
// until writeback accepts it.
module ysyx_22041071_div_issue_ctrl #(
    parameter int XLEN = 64
) (
    input  logic clk,
    input  logic reset,
    ysyx_22041071_div_issue_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;          // {is_w, rem, unsigned}
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [XLEN-1:0] res_q, res_d;

    // funct3[2] is always set for div/rem and carries no information here
    logic unused_op2;
    assign unused_op2 = bus.ex_op[2];

    function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Special-case detection on the incoming op (W forms look at [31:0] only)
    logic            in_w, in_sgn, in_rem, dz, ovf;
    logic [XLEN-1:0] spec_raw, div_raw;

    assign in_w   = bus.ex_op[3];
    assign in_sgn = ~bus.ex_op[0];
    assign in_rem = bus.ex_op[1];
    assign dz     = in_w ? (bus.ex_src2[31:0] == 32'd0) : (bus.ex_src2 == '0);
    assign ovf    = in_sgn & (in_w ?
                    ((bus.ex_src1[31:0] == 32'h8000_0000) && (bus.ex_src2[31:0] == 32'hFFFF_FFFF)) :
                    ((bus.ex_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.ex_src2 == '1)));
    // dz: quot = all ones, rem = dividend; overflow: quot = dividend, rem = 0
    assign spec_raw = in_rem ? (dz ? bus.ex_src1 : '0) : (dz ? '1 : bus.ex_src1);
    assign div_raw  = op_q[1] ? bus.div_rema : bus.div_quot;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic; flush wins over every other transition
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ex_valid && !bus.flush) begin
                    op_d   = {bus.ex_op[3], bus.ex_op[1:0]};
                    src1_d = bus.ex_src1;
                    src2_d = bus.ex_src2;
                    if (dz || ovf) begin
                        res_d   = sext_w(in_w, spec_raw);
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.flush)          state_d = S_IDLE;
                else if (bus.div_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A flush coinciding with the result means nothing is left to drain
                if (bus.flush) begin
                    state_d = bus.div_out_valid ? S_IDLE : S_DRAIN;
                end else if (bus.div_out_valid) begin
                    res_d   = sext_w(op_q[2], div_raw);
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.flush || bus.res_ready) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.div_out_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Divider controls stay stable from issue through the result cycle,
    // and through a drain so the discarded result is still well formed.
    logic div_busy;
    assign div_busy = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DRAIN);

    assign bus.div_valid    = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && !bus.flush;
    assign bus.div_signed   = div_busy && !op_q[0];
    assign bus.div_w        = div_busy && op_q[2];
    assign bus.div_flush    = bus.flush;
    assign bus.div_dividend = src1_q;
    assign bus.div_divisor  = src2_q;
    assign bus.res_valid    = (state_q == S_RESP);
    assign bus.res_data     = res_q;
    assign bus.ex_stall     = bus.ex_valid && !(bus.res_valid && bus.res_ready);
endmodule

// File: tb/tb_ysyx_22041071_div_issue_ctrl.sv
// Directed bench for the divide issue controller with a behavioural divider.
module tb_ysyx_22041071_div_issue_ctrl;
    localparam int LAT = 30;

    logic clk = 1'b0;
    logic reset;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   dv_cnt   = 0;

    always #5 clk = ~clk;

    ysyx_22041071_div_issue_ctrl_if #(.XLEN(64)) dif ();

    ysyx_22041071_div_issue_ctrl #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    // Behavioural divider; W results leave the upper half zero so the
    // controller's sign extension is what makes them correct.
    function automatic logic [63:0] model_div(input logic sg, input logic w, input logic rem,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0)  r32 = 32'd0;
            else if (sg && rem) r32 = $signed(a32) % $signed(b32);
            else if (sg)        r32 = $signed(a32) / $signed(b32);
            else if (rem)       r32 = a32 % b32;
            else                r32 = a32 / b32;
            return {32'd0, r32};
        end
        if (b == 64'd0)     r64 = 64'd0;
        else if (sg && rem) r64 = $signed(a) % $signed(b);
        else if (sg)        r64 = $signed(a) / $signed(b);
        else if (rem)       r64 = a % b;
        else                r64 = a / b;
        return r64;
    endfunction

    logic busy;
    int   dcnt;
    assign dif.div_ready = !busy && !dif.div_out_valid;

    // Divider model: starts on valid&ready, pulses out_valid after LAT cycles
    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            dcnt <= 0;
            dif.div_out_valid <= 1'b0;
            dif.div_quot <= '0;
            dif.div_rema <= '0;
        end else begin
            dif.div_out_valid <= 1'b0;
            if (busy) begin
                if (dcnt == LAT - 1) begin
                    busy <= 1'b0;
                    dif.div_out_valid <= 1'b1;
                    dif.div_quot <= model_div(dif.div_signed, dif.div_w, 1'b0, dif.div_dividend, dif.div_divisor);
                    dif.div_rema <= model_div(dif.div_signed, dif.div_w, 1'b1, dif.div_dividend, dif.div_divisor);
                end else begin
                    dcnt <= dcnt + 1;
                end
            end else if (dif.div_valid && dif.div_ready) begin
                busy <= 1'b1;
                dcnt <= 0;
            end
        end
    end

    always @(posedge clk) if (dif.div_valid) dv_cnt <= dv_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input bit special,
                         input int hold);
        int t0, cyc;
        t0 = dv_cnt;
        @(negedge clk);
        dif.ex_valid = 1'b1; dif.ex_op = op; dif.ex_src1 = a; dif.ex_src2 = b;
        @(negedge clk);
        cyc = 0;
        while (!dif.res_valid && cyc < 2000) begin @(negedge clk); cyc++; end
        chk({tag, "_rv"}, {63'd0, dif.res_valid}, 64'd1);
        if (special) begin
            chk({tag, "_lat"}, 64'(cyc), 64'd0);
            chk({tag, "_nodiv"}, 64'(dv_cnt - t0), 64'd0);
        end else begin
            chk({tag, "_div"}, {63'd0, dv_cnt != t0}, 64'd1);
        end
        chk({tag, "_data"}, dif.res_data, exp);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hstall"}, {63'd0, dif.ex_stall}, 64'd1);
            chk({tag, "_hrv"}, {63'd0, dif.res_valid}, 64'd1);
            chk({tag, "_hdata"}, dif.res_data, exp);
            @(negedge clk);
        end
        dif.res_ready = 1'b1;
        #1;
        chk({tag, "_go"}, {63'd0, dif.ex_stall}, 64'd0);
        @(negedge clk);
        dif.ex_valid = 1'b0; dif.res_ready = 1'b0;
    endtask

    initial begin
        int cyc, t0;
        reset = 1'b1;
        dif.flush = 1'b0; dif.ex_valid = 1'b0; dif.ex_op = '0;
        dif.ex_src1 = '0; dif.ex_src2 = '0; dif.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rv",    {63'd0, dif.res_valid}, 64'd0);
        chk("rst_dv",    {63'd0, dif.div_valid}, 64'd0);
        chk("rst_sgn",   {63'd0, dif.div_signed}, 64'd0);
        chk("rst_data",  dif.res_data, 64'd0);
        chk("rst_stall", {63'd0, dif.ex_stall}, 64'd0);

        do_op("div",   4'b0100, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 5);
        do_op("rem",   4'b0110, 64'd20, -64'sd3, 64'd2, 1'b0, 0);
        do_op("divu0", 4'b0101, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        do_op("remu0", 4'b0111, 64'd7, 64'd0, 64'd7, 1'b1, 0);
        do_op("dovf",  4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1'b1, 0);
        do_op("rovf",  4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
        do_op("remw",  4'b1110, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        do_op("divuw", 4'b1101, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        do_op("divwo", 4'b1100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1'b1, 0);

        // Flush 10 cycles into WAIT while EXE already presents the next op
        @(negedge clk);
        dif.ex_valid = 1'b1; dif.ex_op = 4'b0100; dif.ex_src1 = 64'd100; dif.ex_src2 = 64'd7;
        cyc = 0;
        while (!busy && cyc < 100) begin @(negedge clk); cyc++; end
        chk("fl_started", {63'd0, busy}, 64'd1);
        repeat (10) @(negedge clk);
        dif.flush = 1'b1; dif.ex_op = 4'b0101; dif.ex_src1 = 64'd50; dif.ex_src2 = 64'd5;
        #1;
        chk("fl_dvgate", {63'd0, dif.div_valid}, 64'd0);
        chk("fl_dflush", {63'd0, dif.div_flush}, 64'd1);
        @(negedge clk);
        dif.flush = 1'b0;
        #1;
        chk("dr_dv",    {63'd0, dif.div_valid}, 64'd0);
        chk("dr_rv",    {63'd0, dif.res_valid}, 64'd0);
        chk("dr_stall", {63'd0, dif.ex_stall}, 64'd1);
        t0 = dv_cnt;
        cyc = 0;
        while (!dif.res_valid && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("fl_rv",   {63'd0, dif.res_valid}, 64'd1);
        chk("fl_div",  {63'd0, dv_cnt != t0}, 64'd1);
        chk("fl_data", dif.res_data, 64'd10);
        dif.res_ready = 1'b1;
        @(negedge clk);
        dif.ex_valid = 1'b0; dif.res_ready = 1'b0;

        // Reset in the middle of WAIT
        @(negedge clk);
        dif.ex_valid = 1'b1; dif.ex_op = 4'b0101; dif.ex_src1 = 64'd100; dif.ex_src2 = 64'd3;
        repeat (8) @(negedge clk);
        chk("rw_busy", {63'd0, dif.div_valid}, 64'd1);
        reset = 1'b1; dif.ex_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rw_dv",    {63'd0, dif.div_valid}, 64'd0);
        chk("rw_rv",    {63'd0, dif.res_valid}, 64'd0);
        chk("rw_data",  dif.res_data, 64'd0);
        chk("rw_dend",  dif.div_dividend, 64'd0);
        chk("rw_sgn",   {63'd0, dif.div_signed | dif.div_w}, 64'd0);
        chk("rw_stall", {63'd0, dif.ex_stall}, 64'd0);

        do_op("post", 4'b0101, 64'd100, 64'd3, 64'd33, 1'b0, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
